int0_log_wb_stage: RTL
======================

Name: int0_log_wb_stage

Overview:
- Registered result stage directly downstream of the Int0 Logic unit.
- Captures the 32-bit logic result, its 2-bit condition code and the destination register tag.
- Buffers them in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Presents them to the register-file writeback arbiter, keeps the architectural CC register, and exposes a forwarding tap for the operand-select path.

Parameters:
- DATA_W, 32, result width.
- TAG_W, 5, destination register tag width.
- CC_W, 2, condition code width: bit0 = zero, bit1 = reserved, always 0 from Logic.
- CNT_W, 16, retire counter width.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_i_wb  in  1  upstream result valid.
- rslt_i_wb  in  DATA_W  result from Logic.
- rslt_cc_i_wb  in  CC_W  CC from Logic.
- dst_i_wb  in  TAG_W  destination tag.
- cc_we_i_wb  in  1  entry updates the CC register on retire.
- ready_o_wb  out  1  stage can accept (registered).
- flush_i_wb  in  1  synchronous kill of all buffered entries.
- valid_o_wb  out  1  head entry valid to the arbiter.
- rslt_o_wb  out  DATA_W  head result.
- dst_o_wb  out  TAG_W  head tag.
- ready_i_wb  in  1  arbiter accepts the head.
- cc_o_wb  out  CC_W  architectural CC register.
- fwd_valid_o_wb  out  1  head entry available for forwarding (= main_valid).
- retire_cnt_o_wb  out  CNT_W  number of retired entries, wrapping.

Behaviour:
- Handshake events:
  - accept = valid_i_wb & ready_o_wb & ~flush_i_wb.
  - fire = valid_o_wb & ready_i_wb.
- Storage: main slot (head) and skid slot. Each slot holds {rslt, cc, dst, cc_we}.
- Output gating:
  - valid_o_wb = main_valid & ~flush_i_wb, so no transfer happens in a flush cycle.
  - ready_o_wb = ~skid_valid, a registered signal.
- State machine, 2-bit state (EMPTY, BUSY, FULL):
  - EMPTY: accept -> load main, go to BUSY. Otherwise stay in EMPTY.
  - BUSY, accept & fire -> load main from the input, stay in BUSY.
  - BUSY, accept & ~fire -> load skid, go to FULL.
  - BUSY, ~accept & fire -> go to EMPTY.
  - BUSY, neither -> hold.
  - FULL: fire -> main <= skid, go to BUSY. Otherwise hold. No accept is possible because ready_o_wb = 0.
  - Any state with flush_i_wb = 1 -> go to EMPTY. Both valids clear, no CC update, no counter increment.
- Latency:
  - An accepted input appears on valid_o_wb the next cycle if the stage was EMPTY or firing.
  - Zero-bubble throughput of one entry per cycle while ready_i_wb = 1.
- CC register:
  - On fire with head cc_we = 1, cc_o_wb <= head cc the next cycle.
  - On fire with cc_we = 0, cc_o_wb holds.
  - CC is updated only at retire, never at accept.
- Retire counter: +1 on every fire; wraps from 2^CNT_W-1 to 0.
- Data fields of invalid slots are don't-care but must not X-propagate into valid_o_wb or cc_o_wb.
- rslt_o_wb and dst_o_wb stay stable while valid_o_wb = 1 and ready_i_wb = 0.
- Reset (async, any time including mid-transfer):
  - State goes to EMPTY.
  - valid_o_wb = 0, ready_o_wb = 1, fwd_valid_o_wb = 0.
  - cc_o_wb = 0, retire_cnt_o_wb = 0.
  - rslt_o_wb = 0, dst_o_wb = 0.
- Deassertion of rst_n is synchronous to clk externally; the block only requires async assertion.

Decomposition:
- Shared package int0_pkg holds:
  - DATA_W, TAG_W, CC_W.
  - Entry struct type {rslt, cc, dst, cc_we}.
  - State encoding: EMPTY = 2'b00, BUSY = 2'b01, FULL = 2'b10.
  - CC bit index constants: CC_ZERO = 0, CC_RSVD = 1.
- One natural sub-module, int0_wb_slot: a single entry register with load enable and async clear, instantiated twice (main, skid).
- The FSM, CC register and counter live in the top.

Test Plan:
- Reset, then one entry in: rslt = 0x0000_0000, cc = 2'b01, dst = 3, cc_we = 1, ready_i_wb = 1.
  -> valid_o_wb high one cycle later with the same data. cc_o_wb = 2'b01 the cycle after fire. retire_cnt_o_wb = 1.
- Back-to-back stream of 8 entries, ready_i_wb held 1.
  -> ready_o_wb stays 1, no bubbles, outputs in order, retire_cnt_o_wb = 8.
- ready_i_wb = 0 while feeding 3 entries.
  -> first lands in main, second in skid, ready_o_wb = 0 the next cycle, third held off.
  -> Raise ready_i_wb: order is preserved as 1, 2, 3.
- FULL state, then flush_i_wb pulse with ready_i_wb = 1 in the same cycle.
  -> valid_o_wb = 0 that cycle, no fire, cc_o_wb and counter unchanged.
  -> Next cycle: EMPTY, ready_o_wb = 1.
- Entry with cc_we = 0, cc = 2'b01, retired after cc_o_wb = 2'b00.
  -> cc_o_wb stays 2'b00.
- Counter preset via 65535 fires, then one more fire.
  -> retire_cnt_o_wb wraps to 0.
- Assert rst_n low mid-FULL.
  -> All outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/int0_pkg.sv
// Shared types and constants for the Int0 Logic writeback stage.
package int0_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = 5;
  localparam int unsigned CC_W    = 2;
  localparam int unsigned CNT_W   = 16;

  localparam int unsigned CC_ZERO = 0;
  localparam int unsigned CC_RSVD = 1;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] rslt;
    logic [CC_W-1:0]   cc;
    logic [TAG_W-1:0]  dst;
    logic              cc_we;
  } entry_t;

endpackage

// File: rtl/int0_wb_slot.sv
// Single buffered entry: load-enabled register, cleared to zero on reset.
module int0_wb_slot
  import int0_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  entry_t i_data,
  output entry_t o_data
);

  entry_t r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/int0_log_wb_stage.sv
// Int0 Logic result stage: 2-entry skid buffer feeding the writeback arbiter,
// with architectural CC register, retire counter and forwarding tap.
module int0_log_wb_stage
  import int0_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i_wb,
  input  logic [DATA_W-1:0] rslt_i_wb,
  input  logic [CC_W-1:0]   rslt_cc_i_wb,
  input  logic [TAG_W-1:0]  dst_i_wb,
  input  logic              cc_we_i_wb,
  output logic              ready_o_wb,
  input  logic              flush_i_wb,
  output logic              valid_o_wb,
  output logic [DATA_W-1:0] rslt_o_wb,
  output logic [TAG_W-1:0]  dst_o_wb,
  input  logic              ready_i_wb,
  output logic [CC_W-1:0]   cc_o_wb,
  output logic              fwd_valid_o_wb,
  output logic [CNT_W-1:0]  retire_cnt_o_wb
);

  state_e             r_state;
  logic               r_ready;
  logic [CC_W-1:0]    r_cc;
  logic [CNT_W-1:0]   r_cnt;

  entry_t w_in;
  entry_t w_main;
  entry_t w_skid;
  entry_t w_main_d;
  logic   w_main_valid;
  logic   w_accept;
  logic   w_fire;
  logic   w_load_main;
  logic   w_load_skid;

  assign w_in = '{rslt: rslt_i_wb, cc: rslt_cc_i_wb, dst: dst_i_wb, cc_we: cc_we_i_wb};

  assign w_main_valid = (r_state != EMPTY);
  assign w_accept     = valid_i_wb & r_ready & ~flush_i_wb;
  assign w_fire       = w_main_valid & ready_i_wb & ~flush_i_wb;

  // Head refills from the skid when draining FULL, otherwise from the input.
  assign w_load_main = (w_accept & ((r_state == EMPTY) | ((r_state == BUSY) & w_fire)))
                     | ((r_state == FULL) & w_fire);
  assign w_main_d    = (r_state == FULL) ? w_skid : w_in;
  assign w_load_skid = (r_state == BUSY) & w_accept & ~w_fire;

  int0_wb_slot u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load_main),
    .i_data (w_main_d),
    .o_data (w_main)
  );

  int0_wb_slot u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load_skid),
    .i_data (w_in),
    .o_data (w_skid)
  );

  // Occupancy FSM; ready is registered alongside the state it derives from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else if (flush_i_wb) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) r_state <= BUSY;
          r_ready <= 1'b1;
        end
        BUSY: begin
          if (w_accept && !w_fire) begin
            r_state <= FULL;
            r_ready <= 1'b0;
          end else if (!w_accept && w_fire) begin
            r_state <= EMPTY;
            r_ready <= 1'b1;
          end
        end
        FULL: begin
          if (w_fire) begin
            r_state <= BUSY;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Architectural CC and retire count advance only when the head retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc  <= '0;
      r_cnt <= '0;
    end else if (w_fire) begin
      if (w_main.cc_we) r_cc <= w_main.cc;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign ready_o_wb      = r_ready;
  assign valid_o_wb      = w_main_valid & ~flush_i_wb;
  assign fwd_valid_o_wb  = w_main_valid;
  assign rslt_o_wb       = w_main.rslt;
  assign dst_o_wb        = w_main.dst;
  assign cc_o_wb         = r_cc;
  assign retire_cnt_o_wb = r_cnt;

endmodule
